// File: rtl/gcm_stream_packer.sv
// gcm_stream_packer: packs a 32-bit AAD/text word stream into zero-padded 128-bit blocks
// issued under a done-handshake, then holds the GHASH length block len(A)||len(C).
module gcm_stream_packer #(
    parameter int LEN_W = 64
) (
    input  logic         iClk,
    input  logic         iRstn,
    input  logic         iStart,
    input  logic [31:0]  iData,
    input  logic         iData_valid,
    input  logic         iData_type,
    input  logic         iData_last,
    input  logic [3:0]   iData_keep,
    output logic         oData_ready,
    input  logic         iCore_done,
    output logic [127:0] oAad,
    output logic         oAad_valid,
    output logic         oAad_last,
    output logic [127:0] oBlock,
    output logic         oBlock_valid,
    output logic         oBlock_last,
    output logic [4:0]   oLast_bytes,
    output logic         oLen_valid,
    output logic         oBusy
);
    typedef enum logic [2:0] {IDLE, AAD, TEXT, FLUSH, LEN} state_t;
    state_t state;
    logic [127:0] asm_data, stg_data, asm_next, len_block;
    logic [1:0] asm_idx;
    logic asm_full, asm_type, asm_last, stg_valid, stg_type, stg_last, outstanding, aad_any;
    logic [4:0] asm_bytes, stg_bytes, blk_bytes;
    logic [LEN_W-1:0] aad_bits, txt_bits;
    logic [2:0] wb;
    logic [31:0] word;
    logic type_ok, acc, close, emit, retire, stg_free, issue;
    always_comb begin
        wb = !iData_last ? 3'd4 : iData_keep == 4'b1110 ? 3'd3 : iData_keep == 4'b1100 ? 3'd2 :
             iData_keep == 4'b1000 ? 3'd1 : iData_keep == 4'b0000 ? 3'd0 : 3'd4;
        word = iData & {{8{wb > 3'd0}}, {8{wb > 3'd1}}, {8{wb > 3'd2}}, {8{wb > 3'd3}}};
        asm_next = asm_data | ({word, 96'd0} >> {asm_idx, 5'd0});
        blk_bytes = {1'b0, asm_idx, 2'b00} + {2'b00, wb};
        type_ok = state == AAD ? (!iData_type || !aad_any) : (state == TEXT && iData_type);
    end
    // A closed block waiting in assembly always has a staged block ahead of it
    assign oData_ready = (state == AAD || state == TEXT) && !asm_full;
    assign acc = iData_valid && oData_ready && type_ok;
    assign close = acc && (asm_idx == 2'd3 || iData_last);
    assign emit = close && blk_bytes != 5'd0;
    assign retire = outstanding && iCore_done;
    assign stg_free = !stg_valid || retire;
    assign issue = stg_valid && !outstanding;
    assign len_block = {64'(aad_bits), 64'(txt_bits)};
    always_ff @(posedge iClk) begin
        if (!iRstn) begin
            state <= IDLE;
            asm_data <= '0;
            asm_idx <= '0;
            asm_full <= 1'b0;
            asm_type <= 1'b0;
            asm_last <= 1'b0;
            asm_bytes <= '0;
            stg_data <= '0;
            stg_valid <= 1'b0;
            stg_type <= 1'b0;
            stg_last <= 1'b0;
            stg_bytes <= '0;
            outstanding <= 1'b0;
            aad_any <= 1'b0;
            aad_bits <= '0;
            txt_bits <= '0;
            oAad <= '0;
            oAad_valid <= 1'b0;
            oAad_last <= 1'b0;
            oBlock <= '0;
            oBlock_valid <= 1'b0;
            oBlock_last <= 1'b0;
            oLast_bytes <= '0;
            oLen_valid <= 1'b0;
            oBusy <= 1'b0;
        end else begin
            oAad_valid <= 1'b0;
            oAad_last <= 1'b0;
            oBlock_valid <= 1'b0;
            oBlock_last <= 1'b0;
            // The staged register keeps its block until the core retires it
            if (asm_full && stg_free) begin
                stg_valid <= 1'b1;
                stg_data <= asm_data;
                stg_type <= asm_type;
                stg_last <= asm_last;
                stg_bytes <= asm_bytes;
                asm_full <= 1'b0;
                asm_data <= '0;
            end else if (emit && stg_free) begin
                stg_valid <= 1'b1;
                stg_data <= asm_next;
                stg_type <= iData_type;
                stg_last <= iData_last;
                stg_bytes <= blk_bytes;
            end else if (retire) begin
                stg_valid <= 1'b0;
            end
            if (acc) begin
                asm_type <= iData_type;
                if (!close) begin
                    asm_data <= asm_next;
                    asm_idx <= asm_idx + 2'd1;
                end else begin
                    asm_idx <= '0;
                    asm_data <= (emit && !stg_free) ? asm_next : '0;
                    asm_full <= emit && !stg_free;
                    asm_last <= iData_last;
                    asm_bytes <= blk_bytes;
                end
                if (iData_type) txt_bits <= txt_bits + LEN_W'({wb, 3'b000});
                else aad_bits <= aad_bits + LEN_W'({wb, 3'b000});
            end
            if (issue) begin
                outstanding <= 1'b1;
                if (stg_type) begin
                    oBlock <= stg_data;
                    oBlock_valid <= 1'b1;
                    oBlock_last <= stg_last;
                    if (stg_last) oLast_bytes <= stg_bytes;
                end else begin
                    oAad <= stg_data;
                    oAad_valid <= 1'b1;
                    oAad_last <= stg_last;
                end
            end else if (retire) begin
                outstanding <= 1'b0;
            end
            if (iStart && (state == IDLE || state == LEN)) begin
                aad_bits <= '0;
                txt_bits <= '0;
                aad_any <= 1'b0;
                oLast_bytes <= '0;
            end
            case (state)
                IDLE: if (iStart) begin
                    state <= AAD;
                    oBusy <= 1'b1;
                end
                AAD: if (acc) begin
                    if (iData_type) state <= iData_last ? FLUSH : TEXT;
                    else begin
                        aad_any <= 1'b1;
                        if (iData_last) state <= TEXT;
                    end
                end
                TEXT: if (acc && iData_last) state <= FLUSH;
                FLUSH: if (!asm_full && !stg_valid && !outstanding) begin
                    state <= LEN;
                    oAad <= len_block;
                    oLen_valid <= 1'b1;
                end
                LEN: if (iStart) begin
                    state <= AAD;
                    oLen_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
